// File: rtl/mc_controller.sv
// mc_controller: multi-cycle control FSM for an RV32I core.
// Each instruction is sequenced through FETCH / DECODE / EXEC / MEM / WB.
// Illegal encodings and SYSTEM instructions stop the core in TRAP.
// A memory handshake that does not arrive in time also stops the core in TRAP.
// The core leaves TRAP only through reset.
//
// Parameters:
//   TIMEOUT : cycles to wait for mem_ready before trapping (0 = never trap)
//   CNT_W   : width of the retired-instruction counter
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   instr               current instruction from the IR
//   mem_ready           completes the outstanding imem/dmem request
//   br_taken            ALU branch condition, valid in EXEC
//   imem_req, ir_we     instruction fetch request / IR load
//   dmem_req, dmem_we   data memory request / write
//   rf_we, wb_sel       register write enable / source (0 ALU, 1 mem, 2 pc+4)
//   pc_we, pc_sel       PC update / source (0 pc+4, 1 pc+imm, 2 (rs1+imm)&~1)
//   alu_src_a/b, alu_op ALU operand selects and operation class
//   trapped, trap_cause TRAP status (1 illegal, 2 mem timeout, 3 SYSTEM)
//   instret             retired instruction count (cycles with pc_we)
module mc_controller #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      instr,
    input  logic             mem_ready,
    input  logic             br_taken,
    output logic             imem_req,
    output logic             ir_we,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             rf_we,
    output logic [1:0]       wb_sel,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             alu_src_a,
    output logic             alu_src_b,
    output logic [1:0]       alu_op,
    output logic             trapped,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        C_ILLEGAL = 4'd0,
        C_LOAD    = 4'd1,
        C_STORE   = 4'd2,
        C_OPIMM   = 4'd3,
        C_OP      = 4'd4,
        C_LUI     = 4'd5,
        C_AUIPC   = 4'd6,
        C_JAL     = 4'd7,
        C_JALR    = 4'd8,
        C_BRANCH  = 4'd9,
        C_SYSTEM  = 4'd10
    } iclass_t;

    localparam int WCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WCW-1:0] WAIT_LAST = WCW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam bit TIMEOUT_EN = (TIMEOUT > 0);

    // Classify the instruction; funct3 values that are reserved make it illegal.
    function automatic iclass_t decode_class(input logic [31:0] ins);
        iclass_t    c;
        logic [2:0] f3;
        f3 = ins[14:12];
        case (ins[6:0])
            7'b0000011: c = (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) ? C_ILLEGAL : C_LOAD;
            7'b0100011: c = (f3[2] == 1'b0 && f3 != 3'b011) ? C_STORE : C_ILLEGAL;
            7'b0010011: c = C_OPIMM;
            7'b0110011: c = C_OP;
            7'b0110111: c = C_LUI;
            7'b0010111: c = C_AUIPC;
            7'b1101111: c = C_JAL;
            7'b1100111: c = (f3 == 3'b000) ? C_JALR : C_ILLEGAL;
            7'b1100011: c = (f3 == 3'b010 || f3 == 3'b011) ? C_ILLEGAL : C_BRANCH;
            7'b1110011: c = C_SYSTEM;
            default:    c = C_ILLEGAL;
        endcase
        return c;
    endfunction

    // ALU controls {src_a, src_b, op} for the classes that use the ALU result;
    // shared by EXEC, MEM and WB so the controls stay stable across those states.
    function automatic logic [3:0] alu_ctl(input iclass_t c);
        logic [3:0] r;
        case (c)
            C_LOAD, C_STORE: r = 4'b0_1_00;
            C_OP:            r = 4'b0_0_10;
            C_OPIMM:         r = 4'b0_1_10;
            C_LUI:           r = 4'b0_1_11;
            C_AUIPC:         r = 4'b1_1_00;
            default:         r = 4'b0_0_00;
        endcase
        return r;
    endfunction

    state_t           state_r, state_nx_s;
    logic [WCW-1:0]   wait_cnt_r;
    logic [1:0]       trap_cause_r, cause_nx_s;
    logic [CNT_W-1:0] instret_r;
    iclass_t          cls_s;
    logic             trap_set_s, timeout_hit_s, waiting_s;
    logic             imem_req_s, ir_we_s, dmem_req_s, dmem_we_s, rf_we_s, pc_we_s;
    logic             alu_src_a_s, alu_src_b_s;
    logic [1:0]       wb_sel_s, pc_sel_s, alu_op_s;
    logic             instr_unused_s;

    assign cls_s          = decode_class(instr);
    assign timeout_hit_s  = TIMEOUT_EN ? (wait_cnt_r == WAIT_LAST) : 1'b0;
    assign waiting_s      = ((state_r == S_FETCH) || (state_r == S_MEM)) && !mem_ready;
    assign instr_unused_s = ^{instr[31:15], instr[11:7]};

    // Next-state and strobe decode; every strobe defaults to 0.
    always_comb begin
        state_nx_s  = state_r;
        trap_set_s  = 1'b0;
        cause_nx_s  = 2'd0;
        imem_req_s  = 1'b0;
        ir_we_s     = 1'b0;
        dmem_req_s  = 1'b0;
        dmem_we_s   = 1'b0;
        rf_we_s     = 1'b0;
        wb_sel_s    = 2'd0;
        pc_we_s     = 1'b0;
        pc_sel_s    = 2'd0;
        alu_src_a_s = 1'b0;
        alu_src_b_s = 1'b0;
        alu_op_s    = 2'd0;
        case (state_r)
            S_FETCH: begin
                imem_req_s = 1'b1;
                if (mem_ready) begin
                    ir_we_s    = 1'b1;
                    state_nx_s = S_DECODE;
                end else if (timeout_hit_s) begin
                    state_nx_s = S_TRAP;
                    trap_set_s = 1'b1;
                    cause_nx_s = 2'd2;
                end else begin
                    state_nx_s = S_FETCH;
                end
            end
            S_DECODE: begin
                if (cls_s == C_ILLEGAL) begin
                    state_nx_s = S_TRAP;
                    trap_set_s = 1'b1;
                    cause_nx_s = 2'd1;
                end else if (cls_s == C_SYSTEM) begin
                    state_nx_s = S_TRAP;
                    trap_set_s = 1'b1;
                    cause_nx_s = 2'd3;
                end else begin
                    state_nx_s = S_EXEC;
                end
            end
            S_EXEC: begin
                case (cls_s)
                    C_BRANCH: begin
                        alu_op_s   = 2'd1;
                        pc_we_s    = 1'b1;
                        pc_sel_s   = br_taken ? 2'd1 : 2'd0;
                        state_nx_s = S_FETCH;
                    end
                    C_JAL, C_JALR: begin
                        rf_we_s    = 1'b1;
                        wb_sel_s   = 2'd2;
                        pc_we_s    = 1'b1;
                        pc_sel_s   = (cls_s == C_JALR) ? 2'd2 : 2'd1;
                        state_nx_s = S_FETCH;
                    end
                    C_LOAD, C_STORE: begin
                        {alu_src_a_s, alu_src_b_s, alu_op_s} = alu_ctl(cls_s);
                        state_nx_s = S_MEM;
                    end
                    C_OP, C_OPIMM, C_LUI, C_AUIPC: begin
                        {alu_src_a_s, alu_src_b_s, alu_op_s} = alu_ctl(cls_s);
                        state_nx_s = S_WB;
                    end
                    default: begin
                        // DECODE filters these out; treat a surprise as illegal.
                        state_nx_s = S_TRAP;
                        trap_set_s = 1'b1;
                        cause_nx_s = 2'd1;
                    end
                endcase
            end
            S_MEM: begin
                {alu_src_a_s, alu_src_b_s, alu_op_s} = alu_ctl(cls_s);
                dmem_req_s = 1'b1;
                dmem_we_s  = (cls_s == C_STORE);
                if (mem_ready) begin
                    if (cls_s == C_STORE) begin
                        pc_we_s    = 1'b1;
                        state_nx_s = S_FETCH;
                    end else begin
                        state_nx_s = S_WB;
                    end
                end else if (timeout_hit_s) begin
                    state_nx_s = S_TRAP;
                    trap_set_s = 1'b1;
                    cause_nx_s = 2'd2;
                end else begin
                    state_nx_s = S_MEM;
                end
            end
            S_WB: begin
                {alu_src_a_s, alu_src_b_s, alu_op_s} = alu_ctl(cls_s);
                rf_we_s    = 1'b1;
                wb_sel_s   = (cls_s == C_LOAD) ? 2'd1 : 2'd0;
                pc_we_s    = 1'b1;
                state_nx_s = S_FETCH;
            end
            S_TRAP: begin
                state_nx_s = S_TRAP;
            end
            default: begin
                state_nx_s = S_TRAP;
                trap_set_s = 1'b1;
                cause_nx_s = 2'd1;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Handshake wait counter: restarts on every state change, counts idle cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_r <= '0;
        end else if (state_nx_s != state_r) begin
            wait_cnt_r <= '0;
        end else if (waiting_s) begin
            wait_cnt_r <= wait_cnt_r + WCW'(1);
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    // Trap cause, captured on the transition into TRAP and held there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trap_cause_r <= 2'd0;
        end else if (trap_set_s) begin
            trap_cause_r <= cause_nx_s;
        end else begin
            trap_cause_r <= trap_cause_r;
        end
    end

    // Retired-instruction counter: one per PC update, wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret_r <= '0;
        end else if (pc_we_s) begin
            instret_r <= instret_r + CNT_W'(1);
        end else begin
            instret_r <= instret_r;
        end
    end

    // Strobes are forced low while reset is held, even though state reads FETCH.
    assign imem_req   = rst_n & imem_req_s;
    assign ir_we      = rst_n & ir_we_s;
    assign dmem_req   = rst_n & dmem_req_s;
    assign dmem_we    = rst_n & dmem_we_s;
    assign rf_we      = rst_n & rf_we_s;
    assign wb_sel     = {2{rst_n}} & wb_sel_s;
    assign pc_we      = rst_n & pc_we_s;
    assign pc_sel     = {2{rst_n}} & pc_sel_s;
    assign alu_src_a  = rst_n & alu_src_a_s;
    assign alu_src_b  = rst_n & alu_src_b_s;
    assign alu_op     = {2{rst_n}} & alu_op_s;
    assign trapped    = (state_r == S_TRAP);
    assign trap_cause = trap_cause_r;
    assign instret    = instret_r;

endmodule

// File: tb/tb_mc_controller.sv
// Directed testbench for mc_controller. A second instance with CNT_W=4 shares
// the stimulus so that counter wrap can be observed.
module tb_mc_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = 32'h0;
    logic        mem_ready = 1'b0;
    logic        br_taken = 1'b0;

    logic        imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we;
    logic        alu_src_a, alu_src_b, trapped;
    logic [1:0]  wb_sel, pc_sel, alu_op, trap_cause;
    logic [31:0] instret;

    logic        s_imem_req, s_ir_we, s_dmem_req, s_dmem_we, s_rf_we, s_pc_we;
    logic        s_alu_src_a, s_alu_src_b, s_trapped;
    logic [1:0]  s_wb_sel, s_pc_sel, s_alu_op, s_trap_cause;
    logic [3:0]  s_instret;

    logic [16:0] obs;

    int n_tests = 0;
    int n_fail  = 0;

    // Output bundle bit fields
    localparam logic [16:0] IMEM    = 17'h10000;
    localparam logic [16:0] IRWE    = 17'h08000;
    localparam logic [16:0] DREQ    = 17'h04000;
    localparam logic [16:0] DWE     = 17'h02000;
    localparam logic [16:0] RFWE    = 17'h01000;
    localparam logic [16:0] WB_MEM  = 17'h00400;
    localparam logic [16:0] WB_PC4  = 17'h00800;
    localparam logic [16:0] PCWE    = 17'h00200;
    localparam logic [16:0] PC_IMM  = 17'h00080;
    localparam logic [16:0] PC_JALR = 17'h00100;
    localparam logic [16:0] SRC_A   = 17'h00040;
    localparam logic [16:0] SRC_B   = 17'h00020;
    localparam logic [16:0] AOP_BR  = 17'h00008;
    localparam logic [16:0] AOP_F   = 17'h00010;
    localparam logic [16:0] AOP_B   = 17'h00018;
    localparam logic [16:0] TRP     = 17'h00004;
    localparam logic [16:0] NONE    = 17'h00000;

    localparam logic [31:0] I_ADD   = 32'h002081B3;
    localparam logic [31:0] I_LW    = 32'h0000A183;
    localparam logic [31:0] I_SW    = 32'h0020A023;
    localparam logic [31:0] I_BEQ   = 32'h00000063;
    localparam logic [31:0] I_JAL   = 32'h0000006F;
    localparam logic [31:0] I_JALR  = 32'h00000067;
    localparam logic [31:0] I_LUI   = 32'h000000B7;
    localparam logic [31:0] I_AUIPC = 32'h00000097;
    localparam logic [31:0] I_ECALL = 32'h00000073;

    mc_controller #(.TIMEOUT(16), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .mem_ready(mem_ready), .br_taken(br_taken),
        .imem_req(imem_req), .ir_we(ir_we), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .rf_we(rf_we), .wb_sel(wb_sel), .pc_we(pc_we), .pc_sel(pc_sel),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .trapped(trapped), .trap_cause(trap_cause), .instret(instret)
    );

    mc_controller #(.TIMEOUT(16), .CNT_W(4)) dut_small (
        .clk(clk), .rst_n(rst_n), .instr(instr), .mem_ready(mem_ready), .br_taken(br_taken),
        .imem_req(s_imem_req), .ir_we(s_ir_we), .dmem_req(s_dmem_req), .dmem_we(s_dmem_we),
        .rf_we(s_rf_we), .wb_sel(s_wb_sel), .pc_we(s_pc_we), .pc_sel(s_pc_sel),
        .alu_src_a(s_alu_src_a), .alu_src_b(s_alu_src_b), .alu_op(s_alu_op),
        .trapped(s_trapped), .trap_cause(s_trap_cause), .instret(s_instret)
    );

    assign obs = {imem_req, ir_we, dmem_req, dmem_we, rf_we, wb_sel, pc_we, pc_sel,
                  alu_src_a, alu_src_b, alu_op, trapped, trap_cause};

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic chko(input string tag, input logic [16:0] want);
        chk(tag, {15'd0, obs}, {15'd0, want});
    endtask

    task automatic drive(input logic [31:0] i, input logic r, input logic b);
        instr = i;
        mem_ready = r;
        br_taken = b;
        #1;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        mem_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // FETCH with an immediate handshake followed by DECODE.
    task automatic fetch_decode(input string tag, input logic [31:0] i);
        drive(i, 1'b1, 1'b0); chko({tag, "_fetch"}, IMEM | IRWE); tick();
        drive(i, 1'b1, 1'b0); chko({tag, "_decode"}, NONE); tick();
    endtask

    logic [31:0] illegal_list [5] = '{32'hFFFFFFFF, 32'h00002063, 32'h00001067,
                                      32'h0000B003, 32'h00003023};

    initial begin
        // Reset: strobes low even though memory is ready
        rst_n = 1'b0;
        drive(I_ADD, 1'b1, 1'b1);
        chko("rst_outputs", NONE);
        chk("rst_instret", instret, 32'd0);
        do_reset();

        // ADD: 4 cycles
        fetch_decode("add", I_ADD);
        drive(I_ADD, 1'b1, 1'b0); chko("add_exec", AOP_F); tick();
        drive(I_ADD, 1'b1, 1'b0); chko("add_wb", RFWE | PCWE | AOP_F); tick();
        drive(I_ADD, 1'b0, 1'b0); chko("add_refetch", IMEM);
        chk("add_instret", instret, 32'd1);

        // LW with 3 wait cycles in MEM
        fetch_decode("lw", I_LW);
        drive(I_LW, 1'b1, 1'b0); chko("lw_exec", SRC_B); tick();
        for (int k = 0; k < 3; k++) begin
            drive(I_LW, 1'b0, 1'b0); chko("lw_mem_wait", DREQ | SRC_B); tick();
        end
        drive(I_LW, 1'b1, 1'b0); chko("lw_mem_done", DREQ | SRC_B); tick();
        drive(I_LW, 1'b1, 1'b0); chko("lw_wb", RFWE | WB_MEM | PCWE | SRC_B); tick();
        drive(I_LW, 1'b0, 1'b0); chk("lw_instret", instret, 32'd2);

        // BEQ taken, then not taken
        fetch_decode("beq_t", I_BEQ);
        drive(I_BEQ, 1'b1, 1'b1); chko("beq_taken_exec", PCWE | PC_IMM | AOP_BR); tick();
        fetch_decode("beq_n", I_BEQ);
        drive(I_BEQ, 1'b1, 1'b0); chko("beq_not_exec", PCWE | AOP_BR); tick();

        // Jumps
        fetch_decode("jal", I_JAL);
        drive(I_JAL, 1'b1, 1'b0); chko("jal_exec", RFWE | WB_PC4 | PCWE | PC_IMM); tick();
        fetch_decode("jalr", I_JALR);
        drive(I_JALR, 1'b1, 1'b0); chko("jalr_exec", RFWE | WB_PC4 | PCWE | PC_JALR); tick();

        // LUI and AUIPC
        fetch_decode("lui", I_LUI);
        drive(I_LUI, 1'b1, 1'b0); chko("lui_exec", SRC_B | AOP_B); tick();
        drive(I_LUI, 1'b1, 1'b0); chko("lui_wb", RFWE | PCWE | SRC_B | AOP_B); tick();
        fetch_decode("auipc", I_AUIPC);
        drive(I_AUIPC, 1'b1, 1'b0); chko("auipc_exec", SRC_A | SRC_B); tick();
        drive(I_AUIPC, 1'b1, 1'b0); chko("auipc_wb", RFWE | PCWE | SRC_A | SRC_B); tick();

        // SW with immediate handshake
        fetch_decode("sw", I_SW);
        drive(I_SW, 1'b1, 1'b0); chko("sw_exec", SRC_B); tick();
        drive(I_SW, 1'b1, 1'b0); chko("sw_mem", DREQ | DWE | PCWE | SRC_B); tick();
        drive(I_SW, 1'b0, 1'b0); chko("sw_refetch", IMEM);
        chk("seq_instret", instret, 32'd9);
        chk("seq_instret_small", {28'd0, s_instret}, 32'd9);

        // Illegal encodings trap with cause 1; the first one is watched for 20 cycles
        for (int k = 0; k < 5; k++) begin
            do_reset();
            fetch_decode("illegal", illegal_list[k]);
            drive(illegal_list[k], 1'b1, 1'b1); chko("illegal_trap", TRP | 17'h1);
            if (k == 0) begin
                for (int c = 0; c < 20; c++) begin
                    tick();
                    drive(I_ADD, 1'b1, 1'b1); chko("illegal_hold", TRP | 17'h1);
                end
            end
        end

        // ECALL traps with cause 3
        do_reset();
        fetch_decode("ecall", I_ECALL);
        for (int c = 0; c < 20; c++) begin
            drive(I_SW, 1'b1, 1'b1); chko("ecall_hold", TRP | 17'h3); tick();
        end
        chk("ecall_instret", instret, 32'd0);

        // Fetch timeout: 16 cycles without mem_ready
        do_reset();
        for (int c = 0; c < 16; c++) begin
            drive(I_ADD, 1'b0, 1'b0); chko("tmo_waiting", IMEM); tick();
        end
        drive(I_ADD, 1'b1, 1'b0); chko("tmo_trap", TRP | 17'h2);

        // mem_ready on the 16th cycle wins over the timeout
        do_reset();
        for (int c = 0; c < 15; c++) begin
            drive(I_ADD, 1'b0, 1'b0); tick();
        end
        drive(I_ADD, 1'b1, 1'b0); chko("tmo_last_ready", IMEM | IRWE); tick();
        drive(I_ADD, 1'b0, 1'b0); chko("tmo_decode", NONE); tick();
        drive(I_ADD, 1'b0, 1'b0); chko("tmo_exec", AOP_F);

        // Reset in MEM of SW aborts it
        do_reset();
        fetch_decode("swr", I_SW);
        drive(I_SW, 1'b0, 1'b0); tick();
        drive(I_SW, 1'b0, 1'b0); chko("swr_mem", DREQ | DWE | SRC_B);
        rst_n = 1'b0;
        drive(I_SW, 1'b1, 1'b0); chko("swr_reset_outputs", NONE);
        tick();
        rst_n = 1'b1;
        drive(I_SW, 1'b0, 1'b0); chko("swr_restart", IMEM);
        chk("swr_instret", instret, 32'd0);

        // Counter wrap on the 4-bit instance after 16 retirements
        do_reset();
        for (int n = 0; n < 16; n++) begin
            for (int c = 0; c < 4; c++) begin
                drive(I_ADD, 1'b1, 1'b0); tick();
            end
        end
        drive(I_ADD, 1'b0, 1'b0);
        chk("wrap_instret", instret, 32'd16);
        chk("wrap_instret_small", {28'd0, s_instret}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
